// File: rtl/cond_hs_responder.sv
// Conditional handshake responder: mode-gated req/ack FSM with
// fixed ack latency, plus a first-word fall-through data buffer.
module cond_hs_responder #(
  parameter int DW      = 8,
  parameter int DEPTH   = 4,
  parameter int ACK_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mode,
  input  logic          req,
  output logic          ack,
  input  logic          valid,
  input  logic [DW-1:0] din,
  output logic          ready,
  output logic          dout_valid,
  output logic [DW-1:0] dout,
  input  logic          dout_ready,
  output logic [7:0]    ack_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int LW = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } st_e;

  st_e           st_q;
  logic [LW-1:0] lat_q;
  logic          ack_q;
  logic [7:0]    ackc_q;
  logic          hit;

  assign hit = mode && req;

  // ack and ack_count are registered alongside the WAIT -> ACK move
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= S_IDLE;
      lat_q  <= '0;
      ack_q  <= 1'b0;
      ackc_q <= '0;
    end else begin
      ack_q <= 1'b0;
      unique case (st_q)
        S_IDLE: begin
          if (hit) begin
            st_q  <= S_WAIT;
            lat_q <= LW'(ACK_LAT - 1);
          end
        end
        S_WAIT: begin
          if (!hit) begin
            st_q <= S_IDLE;
          end else if (lat_q == '0) begin
            st_q  <= S_ACK;
            ack_q <= 1'b1;
            if (ackc_q != 8'hFF) ackc_q <= ackc_q + 8'd1;
          end else begin
            lat_q <= lat_q - LW'(1);
          end
        end
        S_ACK:   st_q <= S_IDLE;
        default: st_q <= S_IDLE;
      endcase
    end
  end

  assign ack       = ack_q;
  assign ack_count = ackc_q;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push, pop;

  assign ready      = !mode && (cnt_q < CW'(DEPTH));
  assign dout_valid = (cnt_q != '0);
  assign dout       = mem[rd_q];
  assign push       = valid && ready;
  assign pop        = dout_valid && dout_ready;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) wr_d = wr_q + AW'(1);
    if (pop)  rd_d = rd_q + AW'(1);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // storage holds no reset; dout is meaningless while empty
  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= din;
  end

endmodule

// File: tb/tb_cond_hs_responder.sv
// Directed bench for cond_hs_responder (DW=8, DEPTH=4, ACK_LAT=3).
module tb_cond_hs_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode, req, valid, dout_ready;
  logic [7:0] din;
  logic       ack, ready, dout_valid;
  logic [7:0] dout;
  logic [7:0] ack_count;

  int n_chk = 0;
  int n_err = 0;

  cond_hs_responder #(
    .DW(8), .DEPTH(4), .ACK_LAT(3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .req        (req),
    .ack        (ack),
    .valid      (valid),
    .din        (din),
    .ready      (ready),
    .dout_valid (dout_valid),
    .dout       (dout),
    .dout_ready (dout_ready),
    .ack_count  (ack_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic m);
    mode       = m;
    req        = 1'b0;
    valid      = 1'b0;
    din        = 8'h00;
    dout_ready = 1'b0;
    rst_n      = 1'b0;
    #12;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_cnt", 32'(ack_count), 32'd0);
    chk("rst_dv", 32'(dout_valid), 32'd0);
    chk("rst_rdy", 32'(ready), 32'(!m));
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic push(input logic [7:0] d);
    valid = 1'b1;
    din   = d;
    step();
    valid = 1'b0;
  endtask

  initial begin
    logic [4:0] exp_ack;
    int         lat;
    int         nacks;

    // ack latency with req held
    do_reset(1'b1);
    exp_ack = 5'b01000;
    req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("lat_ack%0d", i), 32'(ack), 32'(exp_ack[i]));
      if (i == 3) begin
        chk("lat_cnt", 32'(ack_count), 32'd1);
        req = 1'b0;
      end
    end
    chk("lat_cnt_end", 32'(ack_count), 32'd1);

    // abort in second WAIT cycle
    do_reset(1'b1);
    req = 1'b1;
    step();
    step();
    req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("abort_ack%0d", i), 32'(ack), 32'd0);
    end
    chk("abort_cnt", 32'(ack_count), 32'd0);

    // fill, overflow attempt, drain
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fill_rdy%0d", i), 32'(ready), 32'd1);
      push(8'h11 * 8'(i + 1));
    end
    chk("full_rdy", 32'(ready), 32'd0);
    push(8'h55);
    chk("full_head", 32'(dout), 32'h11);
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_dv%0d", i), 32'(dout_valid), 32'd1);
      chk($sformatf("drain_d%0d", i), 32'(dout), 32'(8'h11 * 8'(i + 1)));
      step();
    end
    chk("drain_empty", 32'(dout_valid), 32'd0);
    chk("drain_rdy", 32'(ready), 32'd1);
    dout_ready = 1'b0;

    // simultaneous push/pop across pointer wrap
    do_reset(1'b0);
    push(8'hA0);
    push(8'hA1);
    valid      = 1'b1;
    dout_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      din = 8'hA2 + 8'(i);
      chk($sformatf("pp_d%0d", i), 32'(dout), 32'(8'hA0 + 8'(i)));
      step();
      chk($sformatf("pp_rdy%0d", i), 32'(ready), 32'd1);
    end
    valid = 1'b0;
    chk("pp_tail0", 32'(dout), 32'hAA);
    step();
    chk("pp_tail1", 32'(dout), 32'hAB);
    step();
    chk("pp_empty", 32'(dout_valid), 32'd0);
    dout_ready = 1'b0;

    // mode switch with buffered data, then a request
    do_reset(1'b0);
    push(8'h5A);
    push(8'hA5);
    mode = 1'b1;
    #1;
    chk("ms_rdy", 32'(ready), 32'd0);
    dout_ready = 1'b1;
    chk("ms_d0", 32'(dout), 32'h5A);
    step();
    chk("ms_d1", 32'(dout), 32'hA5);
    step();
    chk("ms_empty", 32'(dout_valid), 32'd0);
    dout_ready = 1'b0;
    req = 1'b1;
    lat = 0;
    while (!ack && lat < 10) begin
      step();
      lat++;
    end
    req = 1'b0;
    chk("ms_lat", 32'(lat), 32'd4);
    chk("ms_cnt", 32'(ack_count), 32'd1);

    // saturation, then reset mid-WAIT
    do_reset(1'b1);
    req   = 1'b1;
    nacks = 0;
    for (int i = 0; i < 2000 && nacks < 300; i++) begin
      step();
      if (ack) nacks++;
    end
    chk("sat_acks", 32'(nacks), 32'd300);
    chk("sat_cnt", 32'(ack_count), 32'd255);
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_ack", 32'(ack), 32'd0);
    chk("midrst_cnt", 32'(ack_count), 32'd0);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/cond_hs_responder.md
COND_HS_RESPONDER -- requirements
Module: cond_hs_responder

Interface
REQ-001 Parameter DW, default 8, width of the data channel payload.
REQ-002 Parameter DEPTH, default 4, data buffer entries; power of two, 2..16.
REQ-003 Parameter ACK_LAT, default 1, cycles from request acceptance to ack; legal 1..7.
REQ-004 clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 mode  input  1  channel select: 1 = request channel active, 0 = data channel active.
REQ-007 req  input  1  request, level-held by the requester until ack.
REQ-008 ack  output  1  registered one-cycle acknowledge of req.
REQ-009 valid  input  1  upstream data valid.
REQ-010 din  input  DW  upstream data.
REQ-011 ready  output  1  upstream may push; a push occurs on valid && ready at posedge clk.
REQ-012 dout_valid  output  1  buffer non-empty.
REQ-013 dout  output  DW  head-of-buffer data, first-word fall-through.
REQ-014 dout_ready  input  1  downstream pop; a pop occurs on dout_valid && dout_ready.
REQ-015 ack_count  output  8  number of acks issued, saturating at 255.

Function
REQ-016 The request FSM SHALL have states IDLE, WAIT, ACK.
REQ-017 IDLE -> WAIT when mode && req at posedge; internal latency counter loads ACK_LAT-1.
REQ-018 WAIT: counter decrements each cycle; WAIT -> ACK when counter == 0 and mode && req still high.
REQ-019 ACK_LAT = 1: IDLE -> WAIT -> ACK; ack is high in the cycle exactly ACK_LAT cycles after the accepting edge (the registered cycle following WAIT).
REQ-020 ACK: ack = 1 for exactly one cycle; ACK -> IDLE unconditionally; ack_count increments, saturating at 255.
REQ-021 Abort: in WAIT, if req == 0 or mode == 0 at any posedge, return to IDLE; no ack, no count.
REQ-022 ack SHALL be 0 in every state except ACK.
REQ-023 A req still high in the cycle after ACK SHALL be treated as a new request (IDLE -> WAIT).
REQ-024 ready = !mode && (count < DEPTH); combinational from mode and the registered count only.
REQ-025 Push writes din at wr_ptr; pop advances rd_ptr; pointers wrap modulo DEPTH.
REQ-026 count width is clog2(DEPTH)+1; push-only +1, pop-only -1, simultaneous push and pop: count unchanged, both pointers advance.
REQ-027 Full (count == DEPTH): ready = 0; a valid is ignored, with no write and no pointer change.
REQ-028 Empty (count == 0): dout_valid = 0; dout_ready is ignored; dout is don't-care.
REQ-029 Draining is independent of mode; buffered data SHALL remain poppable while mode = 1.
REQ-030 A mode change SHALL NOT flush the buffer.

Reset
REQ-031 While rst_n = 0, all state is cleared asynchronously:
- FSM = IDLE, latency counter = 0, ack = 0, ack_count = 0.
- Pointers and count = 0, so dout_valid = 0.
REQ-032 Immediately after reset, ready = !mode.
REQ-033 Reset asserted mid-WAIT or mid-ACK SHALL drop ack in the same cycle, with no count increment; buffer contents are lost.
REQ-034 Buffer storage is not reset; dout is don't-care while empty.

Verification
REQ-035 ACK_LAT=3, mode=1, req held high -> ack high for exactly one cycle, 3 cycles after the accepting edge; ack_count = 1; ack low in all other cycles.
REQ-036 ACK_LAT=3, mode=1, req dropped in the 2nd WAIT cycle -> FSM returns to IDLE; ack never asserted; ack_count stays 0.
REQ-037 mode=0, DEPTH=4, push 0x11, 0x22, 0x33, 0x44 with dout_ready=0 -> ready = 0 after the 4th push; a 5th valid with 0x55 is ignored; then popping yields 0x11, 0x22, 0x33, 0x44 in order and dout_valid = 0.
REQ-038 count = 2, push and pop in the same cycle for 10 cycles -> count stays 2; data order preserved across pointer wrap.
REQ-039 Buffer holds 2 entries, mode switched to 1 -> ready = 0 the same cycle; both entries still drain; a req in this state is acked normally.
REQ-040 req held high for 300 ack cycles -> ack_count saturates at 255; rst_n pulsed low mid-WAIT -> ack = 0 and ack_count = 0 immediately.
